// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard controller and its helpers.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_STALL = 2'd1,
    MC_BUSY    = 2'd2
  } hz_state_e;

  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic if_id_flush;
    logic id_ex_flush;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_RUN    = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
                                       if_id_flush: 1'b0, id_ex_flush: 1'b0};
  localparam hz_ctrl_t CTRL_HOLD   = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0,
                                       if_id_flush: 1'b0, id_ex_flush: 1'b0};
  localparam hz_ctrl_t CTRL_BUBBLE = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b1,
                                       if_id_flush: 1'b0, id_ex_flush: 1'b1};
  localparam hz_ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
                                       if_id_flush: 1'b1, id_ex_flush: 1'b1};

endpackage

// File: rtl/hazard_operand_match.sv
// Flags an ID-stage source operand that depends on the load currently in EX.
module hazard_operand_match
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  use_rs1,
  input  logic                  use_rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  mem_read,
  output logic                  hit
);

  // x0 is hardwired to zero, so writing it never creates a dependency.
  assign hit = mem_read & (rd != REG_ADDR_W'(REG_ZERO)) &
               ((use_rs1 & (rs1 == rd)) | (use_rs2 & (rs2 == rd)));

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use bubbles, multi-cycle EX hold, branch flush, stall counter.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MC_LAT            = 4,
  parameter int CNT_W             = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] if_id_rs1,
  input  logic [REG_ADDR_W-1:0] if_id_rs2,
  input  logic                  if_id_use_rs1,
  input  logic                  if_id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic                  id_ex_mem_read,
  input  logic                  ex_mc_start,
  input  logic                  branch_taken,
  output logic                  stall,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_write,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int MAX_CYC = (LOAD_STALL_CYCLES > MC_LAT) ? LOAD_STALL_CYCLES : MC_LAT;
  localparam int REM_W   = $clog2(MAX_CYC) + 1;
  localparam logic [REM_W-1:0] MC_REM = REM_W'(MC_LAT - 2);
  localparam logic [REM_W-1:0] LD_REM = REM_W'((LOAD_STALL_CYCLES > 1) ? LOAD_STALL_CYCLES - 2 : 0);
  localparam bit LD_MULTI = (LOAD_STALL_CYCLES > 1);

  hz_state_e        state;
  logic [REM_W-1:0] rem;
  logic             lu;
  logic             stall_c;
  hz_ctrl_t         ctrl;

  hazard_operand_match #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_match (
    .rs1     (if_id_rs1),
    .rs2     (if_id_rs2),
    .use_rs1 (if_id_use_rs1),
    .use_rs2 (if_id_use_rs2),
    .rd      (id_ex_rd),
    .mem_read(id_ex_mem_read),
    .hit     (lu)
  );

  // Controls react in the same cycle as the hazard, so they decode state and inputs directly.
  always_comb begin
    ctrl    = CTRL_RUN;
    stall_c = 1'b0;
    case (state)
      IDLE: begin
        if (ex_mc_start) begin
          ctrl    = CTRL_HOLD;
          stall_c = 1'b1;
        end else if (branch_taken) begin
          ctrl = CTRL_FLUSH;
        end else if (lu) begin
          ctrl    = CTRL_BUBBLE;
          stall_c = 1'b1;
        end
      end
      MC_BUSY: begin
        ctrl    = CTRL_HOLD;
        stall_c = 1'b1;
      end
      LOAD_STALL: begin
        if (branch_taken) begin
          ctrl = CTRL_FLUSH;
        end else begin
          ctrl    = CTRL_BUBBLE;
          stall_c = 1'b1;
        end
      end
      default: begin
        ctrl    = CTRL_RUN;
        stall_c = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rem          <= '0;
      stall_cycles <= '0;
    end else begin
      if (stall_c && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      case (state)
        IDLE: begin
          if (ex_mc_start) begin
            state <= MC_BUSY;
            rem   <= MC_REM;
          end else if (!branch_taken && lu && LD_MULTI) begin
            state <= LOAD_STALL;
            rem   <= LD_REM;
          end
        end
        MC_BUSY: begin
          if (rem == '0) state <= IDLE;
          else           rem   <= rem - REM_W'(1);
        end
        LOAD_STALL: begin
          if (branch_taken || (rem == '0)) state <= IDLE;
          else                             rem   <= rem - REM_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall       = stall_c;
  assign pc_write    = ctrl.pc_write;
  assign if_id_write = ctrl.if_id_write;
  assign id_ex_write = ctrl.id_ex_write;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_flush = ctrl.id_ex_flush;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: single-cycle load penalty unit and a 3-bubble / 4-bit-counter unit.
module tb_hazard_control_unit;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic [4:0] rd;
    logic       mr;
    logic       mc;
    logic       br;
  } in_t;

  typedef struct packed {
    logic stall;
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic if_id_flush;
    logic id_ex_flush;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  typedef struct {
    int    dut;
    out_t  o;
    string nm;
  } exp_t;

  localparam out_t O_IDLE = 6'b011100;
  localparam out_t O_LOAD = 6'b100101;
  localparam out_t O_MC   = 6'b100000;
  localparam out_t O_BR   = 6'b011111;

  logic clk;
  logic rst_n;
  in_t  in_a, in_b;
  out_t out_a, out_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  logic s_a, pw_a, iw_a, ew_a, if_a, ef_a;
  logic s_b, pw_b, iw_b, ew_b, if_b, ef_b;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  vec_t tbl[18];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hazard_control_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1), .MC_LAT(4), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n),
    .if_id_rs1(in_a.rs1), .if_id_rs2(in_a.rs2),
    .if_id_use_rs1(in_a.use1), .if_id_use_rs2(in_a.use2),
    .id_ex_rd(in_a.rd), .id_ex_mem_read(in_a.mr),
    .ex_mc_start(in_a.mc), .branch_taken(in_a.br),
    .stall(s_a), .pc_write(pw_a), .if_id_write(iw_a), .id_ex_write(ew_a),
    .if_id_flush(if_a), .id_ex_flush(ef_a), .stall_cycles(cnt_a)
  );

  hazard_control_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3), .MC_LAT(4), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n),
    .if_id_rs1(in_b.rs1), .if_id_rs2(in_b.rs2),
    .if_id_use_rs1(in_b.use1), .if_id_use_rs2(in_b.use2),
    .id_ex_rd(in_b.rd), .id_ex_mem_read(in_b.mr),
    .ex_mc_start(in_b.mc), .branch_taken(in_b.br),
    .stall(s_b), .pc_write(pw_b), .if_id_write(iw_b), .id_ex_write(ew_b),
    .if_id_flush(if_b), .id_ex_flush(ef_b), .stall_cycles(cnt_b)
  );

  assign out_a = {s_a, pw_a, iw_a, ew_a, if_a, ef_a};
  assign out_b = {s_b, pw_b, iw_b, ew_b, if_b, ef_b};

  function automatic in_t mk(input int rs1, input int rs2, input bit u1, input bit u2,
                             input int rd, input bit mr, input bit mc, input bit br);
    in_t v;
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.use1 = u1; v.use2 = u2;
    v.rd = 5'(rd); v.mr = mr; v.mc = mc; v.br = br;
    return v;
  endfunction

  task automatic check_front();
    exp_t e;
    out_t act;
    e   = sb.pop_front();
    act = (e.dut == 0) ? out_a : out_b;
    n_cmp++;
    if (act !== e.o) begin
      n_err++;
      $display("FAIL %s: got stall/pcw/ifw/exw/iff/exf=%b required %b", e.nm, act, e.o);
    end
  endtask

  task automatic check_cnt(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: stall_cycles got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic step(input int d, input in_t v, input out_t e, input string nm);
    @(negedge clk);
    if (d == 0) in_a = v;
    else        in_b = v;
    sb.push_back('{d, e, nm});
    #2;
    check_front();
  endtask

  initial begin
    in_t lu3, idl, lu3_br, mc_all;
    int  exp_cnt_a;
    lu3    = mk(5, 0, 1, 0, 5, 1, 0, 0);
    lu3_br = mk(5, 0, 1, 0, 5, 1, 0, 1);
    mc_all = mk(5, 0, 1, 0, 5, 1, 1, 1);
    idl    = '0;

    tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0), O_IDLE};
    tbl[1]  = '{mk(5, 0, 1, 0, 5, 1, 0, 0), O_LOAD};
    tbl[2]  = '{mk(0, 5, 0, 1, 5, 1, 0, 0), O_LOAD};
    tbl[3]  = '{mk(0, 0, 1, 0, 0, 1, 0, 0), O_IDLE};
    tbl[4]  = '{mk(5, 0, 0, 0, 5, 1, 0, 0), O_IDLE};
    tbl[5]  = '{mk(5, 5, 1, 1, 5, 0, 0, 0), O_IDLE};
    tbl[6]  = '{mk(0, 0, 0, 0, 0, 0, 0, 1), O_BR};
    tbl[7]  = '{mk(5, 0, 1, 0, 5, 1, 0, 1), O_BR};
    tbl[8]  = '{mk(7, 3, 1, 1, 3, 1, 0, 0), O_LOAD};
    tbl[9]  = '{mk(7, 3, 1, 1, 9, 1, 0, 0), O_IDLE};
    tbl[10] = '{mk(5, 0, 1, 0, 5, 1, 1, 1), O_MC};
    tbl[11] = '{mk(5, 0, 1, 0, 5, 1, 0, 1), O_MC};
    tbl[12] = '{mk(0, 0, 0, 0, 0, 0, 0, 0), O_MC};
    tbl[13] = '{mk(0, 0, 0, 0, 0, 0, 0, 0), O_MC};
    tbl[14] = '{mk(0, 0, 0, 0, 0, 0, 0, 0), O_IDLE};
    tbl[15] = '{mk(4, 0, 1, 0, 4, 1, 0, 0), O_LOAD};
    tbl[16] = '{mk(0, 4, 0, 1, 4, 1, 0, 0), O_LOAD};
    tbl[17] = '{mk(4, 4, 0, 0, 4, 1, 0, 0), O_IDLE};

    rst_n = 1'b0;
    in_a  = '0;
    in_b  = '0;
    repeat (2) @(negedge clk);
    sb.push_back('{0, O_IDLE, "reset_hold_a"});
    sb.push_back('{1, O_IDLE, "reset_hold_b"});
    #2;
    check_front();
    check_front();
    check_cnt("reset_cnt_a", int'(cnt_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, idl, O_IDLE, "after_reset_a");
    step(1, idl, O_IDLE, "after_reset_b");
    check_cnt("after_reset_cnt_b", int'(cnt_b), 0);

    // Single-bubble unit: one vector per cycle, expected controls from the table.
    exp_cnt_a = 0;
    for (int k = 0; k < 18; k++) begin
      step(0, tbl[k].i, tbl[k].o, $sformatf("vec_a[%0d]", k));
      if (tbl[k].o.stall) exp_cnt_a++;
    end
    @(negedge clk);
    in_a = '0;
    #2;
    check_cnt("table_cnt_a", int'(cnt_a), exp_cnt_a);

    // Three-bubble load-use, hazard input dropped after the first cycle.
    step(1, lu3, O_LOAD, "ld3_c1");
    step(1, idl, O_LOAD, "ld3_c2");
    step(1, idl, O_LOAD, "ld3_c3");
    step(1, idl, O_IDLE, "ld3_release");
    check_cnt("ld3_cnt", int'(cnt_b), 3);

    // Branch during the second load bubble flushes and ends the stall.
    step(1, lu3,    O_LOAD, "ldbr_c1");
    step(1, lu3_br, O_BR,   "ldbr_c2_branch");
    step(1, idl,    O_IDLE, "ldbr_idle");
    check_cnt("ldbr_cnt", int'(cnt_b), 4);

    // Multi-cycle op wins over simultaneous load-use and branch.
    step(1, mc_all, O_MC, "mc_c1");
    step(1, lu3_br, O_MC, "mc_c2");
    step(1, lu3_br, O_MC, "mc_c3");
    step(1, lu3_br, O_MC, "mc_c4");
    step(1, idl,    O_IDLE, "mc_release");
    check_cnt("mc_cnt", int'(cnt_b), 8);

    // Continuous load-use for 20 cycles drives the 4-bit counter into saturation.
    for (int k = 0; k < 20; k++)
      step(1, lu3, O_LOAD, $sformatf("sat_c%0d", k));
    step(1, idl, O_LOAD, "sat_tail_bubble");
    step(1, idl, O_IDLE, "sat_release");
    check_cnt("sat_cnt", int'(cnt_b), 15);

    // Asynchronous reset in the middle of a multi-cycle hold.
    step(1, mk(0, 0, 0, 0, 0, 0, 1, 0), O_MC, "rst_mc_c1");
    step(1, idl, O_MC, "rst_mc_c2");
    #1;
    rst_n = 1'b0;
    sb.push_back('{1, O_IDLE, "rst_mid_mc"});
    #1;
    check_front();
    check_cnt("rst_mid_cnt", int'(cnt_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, idl, O_IDLE, "rst_after_idle");
    step(1, lu3, O_LOAD, "rst_after_lu");
    check_cnt("rst_after_cnt", int'(cnt_b), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
